// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
// Slice count and counter width are derived here so the top and bench agree.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int ndig(input int width, input int digit);
      return width / digit;
   endfunction

   // Counter width never collapses to zero bits, even for a single-slice instance.
   function automatic int cntw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand-in / result-out valid-ready bundle for serial_adder.
// The slave modport is the adder's view; master is the producer/consumer side.
interface serial_adder_if #(
   parameter int WIDTH = 32
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

endinterface

// File: rtl/serial_adder_digit.sv
// DIGIT-bit combinational ripple adder, one slice of the serial datapath.
// Also exposes the carry into its top bit so the caller can form signed overflow.
module adder_digit #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [DIGIT:0] w_c;

   always_comb begin
      w_c    = '0;
      s      = '0;
      w_c[0] = ci;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]     = a[i] ^ b[i] ^ w_c[i];
         w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   end

   assign co       = w_c[DIGIT];
   assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB slice first.
// Subtraction is a + ~b + ~borrow, so cout reads as "no borrow" in sub mode.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);

   localparam int NDIG = ndig(WIDTH, DIGIT);
   localparam int CW   = cntw(NDIG);

   if (WIDTH % DIGIT != 0) begin : gBadDigit
      $error("serial_adder: WIDTH must be a multiple of DIGIT");
   end

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;

   logic [DIGIT-1:0] w_sDig;
   logic [WIDTH-1:0] w_sExt;
   logic             w_co;
   logic             w_cMsbIn;

   // Operands shift right each slice, so the active slice is always the low digit.
   adder_digit #(.DIGIT(DIGIT)) uDigit (
      .a        (r_a[DIGIT-1:0]),
      .b        (r_b[DIGIT-1:0]),
      .ci       (r_carry),
      .s        (w_sDig),
      .co       (w_co),
      .c_msb_in (w_cMsbIn)
   );

   assign w_sExt = WIDTH'(w_sDig);

   assign bus.in_ready  = (r_state == IDLE) && !rst;
   assign bus.out_valid = (r_state == DONE);
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a;
                  r_b     <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.sub ^ bus.cin;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_sum   <= (r_sum >> DIGIT) | (w_sExt << (WIDTH - DIGIT));
               r_carry <= w_co;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == CW'(NDIG - 1)) begin
                  r_cout  <= w_co;
                  r_ovf   <= w_cMsbIn ^ w_co;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a 32/8 instance for directed and corner cases and a
// 32/32 instance for back-to-back random traffic, both against an arithmetic model.
module tb_serial_adder;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] expSum;
      logic        expCout;
      logic        expOvf;
   } vec_t;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst;
   int   passCount  = 0;
   int   checkCount = 0;
   vec_t vecs[7];

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(32)) bus0 ();
   serial_adder_if #(.WIDTH(32)) bus1 ();

   serial_adder #(.WIDTH(32), .DIGIT(8)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   serial_adder #(.WIDTH(32), .DIGIT(32)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // Reference: true integer result, then wrap / carry / signed range test.
   function automatic logic [33:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
      longint ua, ub, c, us, sa, sb, st;
      logic [31:0] s;
      logic co, ov;
      ua = longint'(a);
      ub = longint'(b);
      c  = longint'(cin);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         us = ua - ub - c;
         co = (ua >= ub + c);
         st = sa - sb - c;
      end else begin
         us = ua + ub + c;
         co = (us >= 64'sd4294967296);
         st = sa + sb + c;
      end
      s  = us[31:0];
      ov = (st > SMAX) || (st < SMIN);
      return {co, ov, s};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Waits (bounded) for in_ready, offers one operation, then scrambles the
   // operand bus so any late re-read would be visible.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub);
      int waitCycles = 0;
      while (bus0.in_ready !== 1'b1 && waitCycles < 40) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      checkOutput("accept_ready", 64'(bus0.in_ready), 64'(1));
      bus0.a        = a;
      bus0.b        = b;
      bus0.cin      = cin;
      bus0.sub      = sub;
      bus0.in_valid = 1'b1;
      @(posedge clk); #1;
      bus0.in_valid = 1'b0;
      bus0.a        = $urandom();
      bus0.b        = $urandom();
      bus0.cin      = 1'($urandom());
      bus0.sub      = 1'($urandom());
   endtask

   task automatic waitResult(output int latency);
      latency = 1;
      while (bus0.out_valid !== 1'b1 && latency < 40) begin
         @(posedge clk); #1;
         latency++;
      end
   endtask

   task automatic runOne(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [33:0] expected);
      int lat;
      applyStimulus(a, b, cin, sub);
      waitResult(lat);
      checkOutput({name, "_latency"}, 64'(lat), 64'(5));
      checkOutput({name, "_sum"}, 64'(bus0.sum), 64'(expected[31:0]));
      checkOutput({name, "_cout"}, 64'(bus0.cout), 64'(expected[33]));
      checkOutput({name, "_ovf"}, 64'(bus0.ovf), 64'(expected[32]));
      @(posedge clk); #1;
      checkOutput({name, "_retired"}, 64'(bus0.out_valid), 64'(0));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [33:0] exp0;
      logic [33:0] exp1;
      logic [31:0] ra, rb;
      logic        rc, rs;
      int          lat;

      vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
      vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};

      rst = 1'b1;
      bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
      bus0.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
      bus1.out_ready = 1'b1;

      #3;
      checkOutput("reset_in_ready", 64'(bus0.in_ready), 64'(0));
      checkOutput("reset_out_valid", 64'(bus0.out_valid), 64'(0));
      checkOutput("reset_sum", 64'(bus0.sum), 64'(0));
      checkOutput("reset_cout", 64'(bus0.cout), 64'(0));
      checkOutput("reset_ovf", 64'(bus0.ovf), 64'(0));
      checkOutput("reset_in_ready_d32", 64'(bus1.in_ready), 64'(0));
      #19 rst = 1'b0;
      #1;
      checkOutput("release_in_ready", 64'(bus0.in_ready), 64'(1));
      @(posedge clk); #1;

      // Directed table, expectations written out by hand.
      for (int i = 0; i < 7; i++) begin
         runOne($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                {vecs[i].expCout, vecs[i].expOvf, vecs[i].expSum});
      end

      // Backpressure: result must hold while out_ready is low; in_valid pulse ignored.
      ra = 32'hCAFE_F00D; rb = 32'h1357_9BDF;
      exp0 = refModel(ra, rb, 1'b1, 1'b1);
      bus0.out_ready = 1'b0;
      applyStimulus(ra, rb, 1'b1, 1'b1);
      waitResult(lat);
      checkOutput("bp_latency", 64'(lat), 64'(5));
      for (int k = 0; k < 10; k++) begin
         bus0.in_valid = (k == 3);
         bus0.a = 32'h0BAD_0BAD; bus0.b = 32'h0000_0001; bus0.sub = 1'b0; bus0.cin = 1'b0;
         @(posedge clk); #1;
         checkOutput("bp_out_valid", 64'(bus0.out_valid), 64'(1));
         checkOutput("bp_in_ready", 64'(bus0.in_ready), 64'(0));
         checkOutput("bp_sum", 64'(bus0.sum), 64'(exp0[31:0]));
         checkOutput("bp_cout", 64'(bus0.cout), 64'(exp0[33]));
         checkOutput("bp_ovf", 64'(bus0.ovf), 64'(exp0[32]));
      end
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_retired", 64'(bus0.out_valid), 64'(0));
      checkOutput("bp_idle_ready", 64'(bus0.in_ready), 64'(1));
      ra = 32'h0000_00FF; rb = 32'h0000_0F01;
      runOne("bp_next", ra, rb, 1'b0, 1'b0, refModel(ra, rb, 1'b0, 1'b0));

      // Reset in the second RUN cycle discards the operation.
      applyStimulus(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checkOutput("midrun_sum", 64'(bus0.sum), 64'(0));
      checkOutput("midrun_cout", 64'(bus0.cout), 64'(0));
      checkOutput("midrun_ovf", 64'(bus0.ovf), 64'(0));
      checkOutput("midrun_out_valid", 64'(bus0.out_valid), 64'(0));
      checkOutput("midrun_in_ready", 64'(bus0.in_ready), 64'(0));
      @(posedge clk); #4;
      rst = 1'b0;
      #1;
      checkOutput("midrun_release_ready", 64'(bus0.in_ready), 64'(1));
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         checkOutput("midrun_no_valid", 64'(bus0.out_valid), 64'(0));
      end
      runOne("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
             {1'b0, 1'b0, 32'h2345_6789});

      // Random traffic on the 8-bit-digit instance.
      for (int k = 0; k < 30; k++) begin
         ra = $urandom(); rb = $urandom(); rc = 1'($urandom()); rs = 1'($urandom());
         runOne("rand8", ra, rb, rc, rs, refModel(ra, rb, rc, rs));
      end

      // Single-slice instance, in_valid held high: latency 2, one accept every 3 cycles.
      bus1.in_valid = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         ra = $urandom(); rb = $urandom(); rc = 1'($urandom()); rs = 1'($urandom());
         exp1 = refModel(ra, rb, rc, rs);
         checkOutput("b2b_in_ready", 64'(bus1.in_ready), 64'(1));
         bus1.a = ra; bus1.b = rb; bus1.cin = rc; bus1.sub = rs;
         @(posedge clk); #1;
         bus1.a = $urandom(); bus1.b = $urandom();
         bus1.cin = 1'($urandom()); bus1.sub = 1'($urandom());
         checkOutput("b2b_busy", 64'(bus1.in_ready), 64'(0));
         @(posedge clk); #1;
         checkOutput("b2b_out_valid", 64'(bus1.out_valid), 64'(1));
         checkOutput("b2b_sum", 64'(bus1.sum), 64'(exp1[31:0]));
         checkOutput("b2b_cout", 64'(bus1.cout), 64'(exp1[33]));
         checkOutput("b2b_ovf", 64'(bus1.ovf), 64'(exp1[32]));
         @(posedge clk); #1;
      end
      bus1.in_valid = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised binary adder/subtractor that processes a WIDTH-bit operand pair one DIGIT-bit slice per clock, LSB slice first. A carry register is held between slices. It succeeds the single-bit combinational full-adder cell for wide datapaths, where area matters more than latency. It sits between a valid/ready producer (operand source) and a valid/ready consumer (result sink), and accepts one operation at a time.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of DIGIT.
- DIGIT, 8: bits processed per cycle; NDIG = WIDTH/DIGIT slices (NDIG >= 1).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept; high only in IDLE and while rst is low.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of MSB (sub: 1 = no borrow, 0 = borrow).
- ovf  output  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch A; latch B as b (add) or ~b (sub); carry <= sub ? ~cin : cin; slice counter <= 0; go to RUN.
- RUN: each cycle, adder_digit adds slice[cnt] of A, B and the carry register. The result slice is written into the sum register at position cnt, and the carry register is updated. cnt increments.
- On the last slice (cnt==NDIG-1): cout <= slice carry-out; ovf <= carry into the MSB XOR carry out of the MSB; go to DONE.
- DONE: out_valid=1. sum/cout/ovf are held stable until out_ready=1; on that handshake go to IDLE.
- in_valid/a/b/cin/sub are ignored outside the IDLE handshake cycle. Operands are sampled once and never re-read.
- in_ready is not asserted in DONE. The same-cycle accept/retire is not supported.
- NDIG==1 is legal: RUN lasts one cycle.
- Reset (any state, including mid-RUN or DONE): state<=IDLE; cnt, carry, sum, cout, ovf <= 0; out_valid=0. An in-flight operation is discarded with no partial output.
- Reset values: in_ready=0 while rst high, 1 in the first cycle after release. out_valid=0, sum=0, cout=0, ovf=0.

## Timing
- Accept in cycle T (IDLE). RUN occupies cycles T+1..T+NDIG. out_valid is first high in cycle T+NDIG+1.
- Latency: NDIG+1 cycles from accept to out_valid.
- With out_ready held high: retire in T+NDIG+1, IDLE/in_ready in T+NDIG+2. Minimum initiation interval is NDIG+2 cycles.
- out_ready low: DONE persists indefinitely, and outputs do not change.
- All outputs are registered or a decode of the state register only; there are no combinational input-to-output paths.

## Structure
- Shared package adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function ndig(WIDTH, DIGIT);
  - a counter-width helper, $clog2(NDIG) with a minimum of 1.
- WIDTH % DIGIT != 0 is a elaboration-time error (assertion in the package or the module).
- One sub-module, adder_digit, is a DIGIT-bit combinational ripple adder with these ports:
  - inputs: a, b, ci;
  - outputs: s, co, and c_msb_in (carry into its top bit, used for ovf).
- The top module holds the FSM, counter, operand/sum shift or index registers, and the carry register.

## Test plan
All scenarios use WIDTH=32, DIGIT=8 unless noted.
- Add 0x0000_0001 + 0xFFFF_FFFF, cin=0, sub=0 -> sum=0x0000_0000, cout=1, ovf=0, out_valid exactly 5 cycles after the accept cycle.
- Sub 5 - 7, cin=0 -> sum=0xFFFF_FFFE, cout=0, ovf=0. Sub 7 - 5, cin=1 -> sum=0x0000_0001, cout=1.
- Overflow: 0x7FFF_FFFF + 0x0000_0001 -> sum=0x8000_0000, ovf=1, cout=0. Sub 0x8000_0000 - 1 -> sum=0x7FFF_FFFF, ovf=1.
- Backpressure: out_ready low for 10 cycles in DONE -> sum/cout/ovf stable, out_valid high, in_ready 0. A new in_valid pulse is ignored, and the next result corresponds only to operands offered after in_ready returns.
- Reset asserted asynchronously in the 2nd RUN cycle -> outputs 0 immediately, out_valid never rises for that operation, and in_ready=1 the cycle after release. A following 0x1234_5678 + 0x1111_1111 yields 0x2345_6789.
- DIGIT=32 instance with out_ready tied high, back-to-back in_valid -> latency 2 cycles, accepts every 3 cycles, results match the reference model for 1000 random add/sub vectors.
